// File: rtl/mesh_if_core.sv
// 16-terminal packet interconnect. It routes each ingress head packet by its row/col
// destination into a per-egress first-word-fall-through FIFO, with round-robin arbitration per egress.
module mesh_if_core #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng_i_in    [0:15],
    input  logic [pckg_sz-1:0] data_out_i_in [0:15],
    output logic               popin         [0:15],
    output logic               pndng         [0:15],
    output logic [pckg_sz-1:0] data_out      [0:15],
    input  logic               pop           [0:15]
);

    localparam int n_term = 16;
    localparam int ptr_w  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cnt_w  = $clog2(fifo_depth + 1);

    // Destination decode
    logic [3:0] row_f   [0:n_term-1];
    logic [3:0] col_f   [0:n_term-1];
    logic [3:0] dest    [0:n_term-1];
    logic       dest_ok [0:n_term-1];

    always_comb begin
        for (int i = 0; i < n_term; i++) begin
            row_f[i]   = data_out_i_in[i][pckg_sz-9  -: 4];
            col_f[i]   = data_out_i_in[i][pckg_sz-13 -: 4];
            dest_ok[i] = (row_f[i] <= 4'd3) && (col_f[i] <= 4'd3);
            dest[i]    = {row_f[i][1:0], col_f[i][1:0]};
        end
    end

    // Request matrix: req[j][i] means ingress i wants egress j
    logic [n_term-1:0] req [0:n_term-1];

    always_comb begin
        for (int j = 0; j < n_term; j++) begin
            req[j] = '0;
            for (int i = 0; i < n_term; i++) begin
                if (pndng_i_in[i] && dest_ok[i] && (dest[i] == 4'(j)))
                    req[j][i] = 1'b1;
            end
        end
    end

    // Egress FIFO state
    logic [pckg_sz-1:0] mem    [0:n_term-1][0:fifo_depth-1];
    logic [ptr_w-1:0]   rd_ptr [0:n_term-1];
    logic [ptr_w-1:0]   wr_ptr [0:n_term-1];
    logic [cnt_w-1:0]   count  [0:n_term-1];
    logic [3:0]         rr     [0:n_term-1];

    logic       can_push  [0:n_term-1];
    logic       gnt_valid [0:n_term-1];
    logic [3:0] gnt_idx   [0:n_term-1];
    logic       do_pop    [0:n_term-1];
    logic [3:0] arb_idx;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(fifo_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin arbiters. A full FIFO still accepts when it is popped in the same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        arb_idx = '0;
        for (int j = 0; j < n_term; j++) begin
            can_push[j]  = reset && ((count[j] != cnt_w'(fifo_depth)) || pop[j]);
            gnt_valid[j] = 1'b0;
            gnt_idx[j]   = '0;
            if (can_push[j]) begin
                for (int k = 0; k < n_term; k++) begin
                    // NOTE: blocking assignments are correct here because this is combinational scratch logic.
                    arb_idx = rr[j] + 4'(k);
                    if (!gnt_valid[j] && req[j][arb_idx]) begin
                        gnt_valid[j] = 1'b1;
                        gnt_idx[j]   = arb_idx;
                    end
                end
            end
        end
    end

    // Invalid destinations are dropped at once; valid ones pop only on grant.
    always_comb begin
        for (int i = 0; i < n_term; i++) begin
            popin[i] = 1'b0;
            if (reset && pndng_i_in[i]) begin
                if (!dest_ok[i])
                    popin[i] = 1'b1;
                else if (gnt_valid[dest[i]] && (gnt_idx[dest[i]] == 4'(i)))
                    popin[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < n_term; j++) begin
            do_pop[j]   = pop[j] && (count[j] != '0);
            pndng[j]    = (count[j] != '0);
            data_out[j] = pndng[j] ? mem[j][rd_ptr[j]] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < n_term; j++) begin
                rd_ptr[j] <= '0;
                wr_ptr[j] <= '0;
                count[j]  <= '0;
                rr[j]     <= '0;
            end
        end else begin
            for (int j = 0; j < n_term; j++) begin
                if (gnt_valid[j]) begin
                    wr_ptr[j] <= ptr_inc(wr_ptr[j]);
                    rr[j]     <= gnt_idx[j] + 4'd1;
                end
                if (do_pop[j])
                    rd_ptr[j] <= ptr_inc(rd_ptr[j]);
                case ({gnt_valid[j], do_pop[j]})
                    2'b10:   count[j] <= count[j] + 1'b1;
                    2'b01:   count[j] <= count[j] - 1'b1;
                    default: count[j] <= count[j];
                endcase
            end
        end
    end

    // NOTE: storage has no reset. A zero count masks stale entries, and data_out reads 0 when empty.
    always_ff @(posedge clk) begin
        for (int j = 0; j < n_term; j++) begin
            if (gnt_valid[j])
                mem[j][wr_ptr[j]] <= data_out_i_in[gnt_idx[j]];
        end
    end

endmodule

// File: tb/tb_mesh_if_core.sv
// Directed bench for mesh_if_core: reset, routing, invalid drop, round-robin,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_mesh_if_core;

    localparam int pw = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          pndng_i_in    [0:15];
    logic [pw-1:0] data_out_i_in [0:15];
    logic          popin         [0:15];
    logic          pndng         [0:15];
    logic [pw-1:0] data_out      [0:15];
    logic          pop           [0:15];

    int passed = 0;
    int total  = 0;

    mesh_if_core #(.pckg_sz(pw), .fifo_depth(4)) dut (
        .clk(clk),
        .reset(reset),
        .pndng_i_in(pndng_i_in),
        .data_out_i_in(data_out_i_in),
        .popin(popin),
        .pndng(pndng),
        .data_out(data_out),
        .pop(pop)
    );

    always #5 clk = ~clk;

    function automatic logic [pw-1:0] mk(input int row, input int col, input int pay);
        return {8'h00, 4'(row), 4'(col), 1'b0, 23'(pay)};
    endfunction

    function automatic logic [15:0] pndng_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = pndng[i];
        return v;
    endfunction

    function automatic logic [15:0] popin_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = popin[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order [6] = '{1, 2, 3, 1, 2, 3};
    logic [pw-1:0] bp [6];
    logic [pw-1:0] q  [3];
    logic [pw-1:0] w;

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pndng_i_in[i]    = 1'b0;
            data_out_i_in[i] = '0;
            pop[i]           = 1'b0;
        end
        tick();
        tick();
        check("reset_pndng", 64'(pndng_vec()), 64'h0);
        check("reset_popin", 64'(popin_vec()), 64'h0);

        // Leave a stale entry in egress 4, then reset while ingress 6 is pending.
        reset = 1'b1;
        pndng_i_in[0] = 1'b1; data_out_i_in[0] = mk(1, 0, 1);
        #1 check("stale_popin", 64'(popin_vec()), 64'h0001);
        tick();
        pndng_i_in[0] = 1'b0;
        #1 check("stale_pndng", 64'(pndng_vec()), 64'h0010);
        pndng_i_in[6] = 1'b1; data_out_i_in[6] = mk(1, 0, 2);
        reset = 1'b0;
        #1 check("async_rst_pndng", 64'(pndng_vec()), 64'h0);
        check("rst_forces_popin", 64'(popin_vec()), 64'h0);
        tick();
        pndng_i_in[6] = 1'b0;
        reset = 1'b1;
        tick();
        check("post_release_pndng", 64'(pndng_vec()), 64'h0);

        // Single route: ingress 0 to terminal 5
        w = mk(1, 1, 'hA5);
        pndng_i_in[0] = 1'b1; data_out_i_in[0] = w;
        #1 check("route_popin", 64'(popin_vec()), 64'h0001);
        tick();
        pndng_i_in[0] = 1'b0;
        #1 check("route_pndng", 64'(pndng_vec()), 64'h0020);
        check("route_data", 64'(data_out[5]), 64'(w));
        pop[5] = 1'b1;
        tick();
        pop[5] = 1'b0;
        #1 check("route_drained", 64'(pndng_vec()), 64'h0);
        check("route_data_empty", 64'(data_out[5]), 64'h0);

        // Invalid destination: row 6
        pndng_i_in[3] = 1'b1; data_out_i_in[3] = mk(6, 0, 3);
        #1 check("invalid_popin", 64'(popin_vec()), 64'h0008);
        tick();
        pndng_i_in[3] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1 check("invalid_no_egress", 64'(pndng_vec()), 64'h0);
            tick();
        end

        // Round-robin: ingresses 1,2,3 all target terminal 7, with pop held high
        for (int i = 1; i <= 3; i++) begin
            pndng_i_in[i] = 1'b1; data_out_i_in[i] = mk(1, 3, i);
        end
        pop[7] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 check("rr_grant", 64'(popin_vec()), 64'(16'd1 << order[c]));
            if (c > 0) check("rr_data", 64'(data_out[7]), 64'(mk(1, 3, order[c-1])));
            tick();
        end
        for (int i = 1; i <= 3; i++) pndng_i_in[i] = 1'b0;
        #1 check("rr_last_data", 64'(data_out[7]), 64'(mk(1, 3, 3)));
        tick();
        pop[7] = 1'b0;
        #1 check("rr_drained", 64'(pndng_vec()), 64'h0);

        // Backpressure: ingress 10 sends to terminal 9 with no pop
        for (int k = 0; k < 6; k++) bp[k] = mk(2, 1, 'h100 + k);
        for (int k = 0; k < 4; k++) begin
            pndng_i_in[10] = 1'b1; data_out_i_in[10] = bp[k];
            #1 check("bp_accept", 64'(popin_vec()), 64'h0400);
            tick();
        end
        data_out_i_in[10] = bp[4];
        #1 check("bp_blocked", 64'(popin_vec()), 64'h0);
        tick();
        check("bp_still_blocked", 64'(popin_vec()), 64'h0);
        check("bp_head", 64'(data_out[9]), 64'(bp[0]));
        pop[9] = 1'b1;
        #1 check("bp_pop_push", 64'(popin_vec()), 64'h0400);
        tick();
        pop[9] = 1'b0;
        data_out_i_in[10] = bp[5];
        #1 check("bp_full_again", 64'(popin_vec()), 64'h0);
        pndng_i_in[10] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pop[9] = 1'b1;
            #1 check("bp_drain_order", 64'(data_out[9]), 64'(bp[k]));
            tick();
        end
        pop[9] = 1'b0;
        #1 check("bp_drained", 64'(pndng_vec()), 64'h0);

        // Reset mid-operation: egress 2 holds 3 packets
        for (int k = 0; k < 3; k++) q[k] = mk(0, 2, 'h200 + k);
        for (int k = 0; k < 3; k++) begin
            pndng_i_in[12] = 1'b1; data_out_i_in[12] = q[k];
            tick();
        end
        pndng_i_in[12] = 1'b0;
        #1 check("mid_loaded", 64'(pndng_vec()), 64'h0004);
        check("mid_head", 64'(data_out[2]), 64'(q[0]));
        reset = 1'b0;
        #1 check("mid_rst_pndng", 64'(pndng_vec()), 64'h0);
        check("mid_rst_data", 64'(data_out[2]), 64'h0);
        tick();
        reset = 1'b1;
        w = mk(0, 2, 'h2FF);
        pndng_i_in[12] = 1'b1; data_out_i_in[12] = w;
        #1 check("mid_new_popin", 64'(popin_vec()), 64'h1000);
        tick();
        pndng_i_in[12] = 1'b0;
        #1 check("mid_new_pndng", 64'(pndng_vec()), 64'h0004);
        check("mid_new_data", 64'(data_out[2]), 64'(w));
        pop[2] = 1'b1;
        tick();
        pop[2] = 1'b0;
        #1 check("mid_no_old", 64'(pndng_vec()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mesh_if_core.md
Name: mesh_if_core

Overview:
- 16-terminal packet interconnect for the mesh test environment. Each terminal has one ingress port and one egress port.
- Each ingress port sits in front of an external terminal FIFO that presents a pending flag and a head word.
- The block routes each packet to the egress FIFO selected by its destination field, arbitrating round-robin per egress.
- Sits between the per-terminal driver FIFOs and the per-terminal monitors.

Parameters:
- pckg_sz, 40, packet width in bits (min 20).
- fifo_depth, 4, entries per egress FIFO (min 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pndng_i_in[0:15]  input  16x1  ingress terminal i has a packet at its head.
- data_out_i_in[0:15]  input  16 x pckg_sz  head packet of ingress terminal i.
- popin[0:15]  output  16x1  pop strobe to ingress terminal i; consumes its head at this clock edge.
- pndng[0:15]  output  16x1  egress FIFO j not empty.
- data_out[0:15]  output  16 x pckg_sz  head of egress FIFO j (first-word fall-through).
- pop[0:15]  input  16x1  terminal j consumes egress head at this clock edge.

Behaviour:
- Packet fields:
  - [pckg_sz-1:pckg_sz-8] next-jump, ignored.
  - [pckg_sz-9:pckg_sz-12] dest row.
  - [pckg_sz-13:pckg_sz-16] dest col.
  - [pckg_sz-17] mode, ignored.
  - Remaining bits are payload.
- Destination terminal = row*4+col. Valid only if row<=3 and col<=3; otherwise the packet is invalid.
- Packets are forwarded bit-exact, with no field modification.
- Request: ingress i requests egress j when pndng_i_in[i]=1 and its valid destination = j.
- Invalid-destination packets:
  - popin[i] is asserted immediately, with no arbitration.
  - The packet is discarded.
  - It never appears on any egress.
- Arbitration:
  - One combinational round-robin arbiter per egress j.
  - Each arbiter has a 4-bit pointer rr[j], reset value 0.
  - Search starts at index rr[j] and wraps at 15.
  - The first requesting ingress is granted.
  - At most one grant per egress per cycle. An ingress can request only one egress, so there is no cross-egress conflict.
- Grant condition: egress FIFO j not full, OR pop[j]=1 in the same cycle (simultaneous pop-and-push on a full FIFO is allowed).
- On grant to ingress i:
  - popin[i]=1 (combinational, same cycle).
  - data_out_i_in[i] is written into egress FIFO j at the rising edge.
  - rr[j] <= i+1 mod 16.
- Backpressure: if egress j is full and pop[j]=0, there is no grant and popin stays 0. The packet waits at the ingress head and no data is lost.
- Latency: a packet granted in cycle k has pndng[j]=1 and is visible on data_out[j] after edge k (one cycle through an empty FIFO).
- Egress FIFO:
  - Circular buffer with read/write pointers and a count (0..fifo_depth).
  - pndng[j] = (count != 0).
  - data_out[j] = entry at the read pointer; 0 when empty.
- Egress pop:
  - pop[j]=1 with count>0 advances the read pointer.
  - pop[j]=1 with count=0 is ignored: no underflow, no pointer movement.
- Simultaneous push and pop on the same egress: count unchanged; both pointers advance.
- Per-egress ordering: FIFO order within an egress. Packets from the same ingress to the same egress are never reordered.
- Reset (reset=0):
  - Asynchronously clears all counts, pointers and rr[].
  - pndng=0 and data_out=0 immediately.
  - popin is forced to 0 combinationally while reset=0.
  - Packets held in egress FIFOs at reset are lost.
  - Ingress packets are untouched, since they are held externally.
- First cycle after reset release: arbitration is active; packets pending at the ingress may be granted in that cycle.
- Hard requirement: pndng[j] must be 0 no later than 4 clocks after reset assertion. This design achieves it immediately.

Test Plan:
- Reset check: assert reset=0 with stale egress contents -> pndng=16'h0000 and popin=0 during reset; pndng still 0 one cycle after release with no traffic.
- Single route: ingress 0 presents row=1, col=1, payload 0xA5 -> popin[0] pulses 1 cycle; next cycle pndng[5]=1 and data_out[5] equals the sent word bit-exact; pop[5] -> pndng[5]=0.
- Invalid destination: ingress 3 presents row=6, col=0 -> popin[3] pulses; pndng stays 16'h0000 for 10 cycles.
- Round-robin contention: ingresses 1, 2 and 3 all target terminal 7 continuously, pop[7] held 1 -> grant order 1, 2, 3, 1, 2, 3; one packet per cycle.
- Backpressure: 5 packets to terminal 9, pop[9]=0 -> first 4 accepted; 5th ingress sees popin=0 and waits. Then pop[9] for one cycle -> 5th accepted in that same cycle; count stays 4; the 4 packets drain out in send order.
- Reset mid-operation: egress 2 holding 3 packets, assert reset=0 -> pndng[2]=0 asynchronously; after release, new packets to terminal 2 arrive with 1-cycle latency and none of the old packets reappear.
